mem_port_arbiter: RTL and testbench

- Shares the single backing data memory between two miss requesters: the instruction-cache refill port (I) and the data-cache miss/write-back port (D).
- Sits between the cache controllers and the memory array.
- Serialises accesses, holds memory controls stable for a fixed latency, returns read data, and pulses a one-cycle acknowledge.
- Arbitration is round-robin, so neither side starves under back-to-back misses.

---
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the I/D miss requesters, the shared memory array and the arbiter.
// The master modport is the arbiter's view; slave is the requester/memory side.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic [DATA_W-1:0] i_rdata;
   logic              i_ack;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [3:0]        d_be;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ack;

   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [3:0]        mem_be;
   logic              mem_ren;
   logic              mem_wen;
   logic [DATA_W-1:0] mem_rdata;

   logic              busy;

   modport master (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
      output i_rdata, i_ack, d_rdata, d_ack,
      output mem_addr, mem_wdata, mem_be, mem_ren, mem_wen, busy
   );

   modport slave (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
      input  i_rdata, i_ack, d_rdata, d_ack,
      input  mem_addr, mem_wdata, mem_be, mem_ren, mem_wen, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one data memory between the I-cache refill port and the
// D-cache miss/write-back port; each access holds memory controls for MEM_LATENCY cycles.
module mem_port_arbiter #(
   parameter int MEM_LATENCY = 2,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32
) (
   input logic                clk,
   input logic                reset,
   mem_port_arbiter_if.master bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic       OWN_I    = 1'b0;
   localparam logic       OWN_D    = 1'b1;
   localparam logic [3:0] LAST_CNT = 4'(MEM_LATENCY - 1);

   state_t            state;
   state_t            state_nxt;
   logic [3:0]        count;
   logic              last_grant;
   logic              owner_l;
   logic              we_l;
   logic [3:0]        be_l;
   logic [ADDR_W-1:0] addr_l;
   logic [DATA_W-1:0] wdata_l;
   logic [DATA_W-1:0] i_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;

   logic              grant_vld;
   logic              grant_owner;
   logic              mem_ren_c;
   logic              mem_wen_c;
   logic [3:0]        mem_be_c;
   logic              i_ack_c;
   logic              d_ack_c;

   // A tie goes to the side that did not win last time; a lone request simply wins.
   function automatic logic pick_owner(input logic req_i, input logic req_d,
                                       input logic last);
      if (req_i && req_d)
         return ~last;
      return req_d ? OWN_D : OWN_I;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      grant_vld   = 1'b0;
      grant_owner = OWN_I;
      mem_ren_c   = 1'b0;
      mem_wen_c   = 1'b0;
      mem_be_c    = 4'h0;
      i_ack_c     = 1'b0;
      d_ack_c     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.i_req || bus.d_req) begin
               grant_vld   = 1'b1;
               grant_owner = pick_owner(bus.i_req, bus.d_req, last_grant);
               state_nxt   = ACCESS;
            end
         end
         ACCESS: begin
            mem_ren_c = ~we_l;
            mem_wen_c = we_l;
            // Only D writes carry partial byte enables; reads always fetch the full word.
            mem_be_c  = we_l ? be_l : 4'hF;
            if (count == LAST_CNT)
               state_nxt = DONE;
         end
         DONE: begin
            i_ack_c   = (owner_l == OWN_I);
            d_ack_c   = (owner_l == OWN_D);
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count      <= 4'd0;
         last_grant <= OWN_D;
         owner_l    <= OWN_I;
         we_l       <= 1'b0;
         be_l       <= 4'h0;
         addr_l     <= '0;
         wdata_l    <= '0;
         i_rdata_q  <= '0;
         d_rdata_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_vld) begin
                  owner_l    <= grant_owner;
                  last_grant <= grant_owner;
                  count      <= 4'd0;
                  if (grant_owner == OWN_D) begin
                     addr_l  <= bus.d_addr;
                     we_l    <= bus.d_we;
                     wdata_l <= bus.d_wdata;
                     be_l    <= bus.d_be;
                  end else begin
                     addr_l  <= bus.i_addr;
                     we_l    <= 1'b0;
                     be_l    <= 4'hF;
                  end
               end
            end
            ACCESS: begin
               count <= count + 4'd1;
               // Memory data is taken on the last edge of the hold window.
               if (count == LAST_CNT) begin
                  if (owner_l == OWN_I)
                     i_rdata_q <= bus.mem_rdata;
                  else if (!we_l)
                     d_rdata_q <= bus.mem_rdata;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.mem_addr  = addr_l;
   assign bus.mem_wdata = wdata_l;
   assign bus.mem_be    = mem_be_c;
   assign bus.mem_ren   = mem_ren_c;
   assign bus.mem_wen   = mem_wen_c;
   assign bus.i_rdata   = i_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.i_ack     = i_ack_c;
   assign bus.d_ack     = d_ack_c;
   assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a word-addressed memory model behind the bus.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(.MEM_LATENCY(2), .ADDR_W(32), .DATA_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [31:0] mem_q [0:255];
   logic        pl_en;
   logic [7:0]  pl_idx;
   logic [31:0] pl_data;

   always @(posedge clk) begin
      if (pl_en)
         mem_q[pl_idx] <= pl_data;
      else if (bus.mem_wen)
         for (int b = 0; b < 4; b++)
            if (bus.mem_be[b])
               mem_q[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
   end

   assign bus.mem_rdata = mem_q[bus.mem_addr[9:2]];

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic preload(input logic [7:0] idx, input logic [31:0] data);
      @(negedge clk);
      pl_idx  = idx;
      pl_data = data;
      pl_en   = 1'b1;
      @(negedge clk);
      pl_en   = 1'b0;
   endtask

   task automatic test_reset();
      tick();
      checks++;
      if ({bus.i_rdata, bus.d_rdata, bus.i_ack, bus.d_ack, bus.mem_addr, bus.mem_wdata,
           bus.mem_be, bus.mem_ren, bus.mem_wen, bus.busy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got i_rd=%h d_rd=%h addr=%h be=%b ren=%b wen=%b busy=%b want all 0",
                  bus.i_rdata, bus.d_rdata, bus.mem_addr, bus.mem_be, bus.mem_ren, bus.mem_wen, bus.busy);
      end
      reset = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++;
         if ({bus.busy, bus.mem_ren, bus.mem_wen, bus.i_ack, bus.d_ack, bus.mem_be} !== 9'd0) begin
            errors++;
            $display("FAIL idle_quiet cycle %0d got busy=%b ren=%b wen=%b acks=%b%b be=%b want 0",
                     c, bus.busy, bus.mem_ren, bus.mem_wen, bus.i_ack, bus.d_ack, bus.mem_be);
         end
      end
   endtask

   task automatic test_i_read();
      bus.i_addr = 32'h100;
      bus.i_req  = 1'b1;
      tick();
      checks++;
      if ({bus.mem_ren, bus.mem_wen, bus.busy} !== 3'b101) begin
         errors++; $display("FAIL ird_c1_ctl got ren/wen/busy=%b want 101", {bus.mem_ren, bus.mem_wen, bus.busy});
      end
      checks++;
      if (bus.mem_addr !== 32'h100 || bus.mem_be !== 4'hF) begin
         errors++; $display("FAIL ird_c1_addr got addr=%h be=%b want 00000100 1111", bus.mem_addr, bus.mem_be);
      end
      bus.i_addr = 32'h3FC;
      tick();
      checks++;
      if (bus.mem_ren !== 1'b1 || bus.i_ack !== 1'b0 || bus.mem_addr !== 32'h100) begin
         errors++; $display("FAIL ird_c2 got ren=%b ack=%b addr=%h want 1 0 00000100", bus.mem_ren, bus.i_ack, bus.mem_addr);
      end
      tick();
      checks++;
      if ({bus.i_ack, bus.d_ack, bus.mem_ren} !== 3'b100) begin
         errors++; $display("FAIL ird_ack got i_ack/d_ack/ren=%b want 100", {bus.i_ack, bus.d_ack, bus.mem_ren});
      end
      checks++;
      if (bus.i_rdata !== 32'hDEADBEEF) begin
         errors++; $display("FAIL ird_data got %h want deadbeef", bus.i_rdata);
      end
      bus.i_req = 1'b0;
      tick();
      checks++;
      if (bus.i_ack !== 1'b0 || bus.busy !== 1'b0 || bus.i_rdata !== 32'hDEADBEEF || bus.mem_addr !== 32'h100) begin
         errors++; $display("FAIL ird_after got ack=%b busy=%b rd=%h addr=%h want 0 0 deadbeef 00000100",
                            bus.i_ack, bus.busy, bus.i_rdata, bus.mem_addr);
      end
   endtask

   task automatic test_d_write();
      bus.d_addr  = 32'h40;
      bus.d_wdata = 32'h12345678;
      bus.d_be    = 4'b0011;
      bus.d_we    = 1'b1;
      bus.d_req   = 1'b1;
      tick();
      checks++;
      if ({bus.mem_ren, bus.mem_wen} !== 2'b01 || bus.mem_be !== 4'b0011) begin
         errors++; $display("FAIL dwr_c1_ctl got ren/wen=%b be=%b want 01 0011", {bus.mem_ren, bus.mem_wen}, bus.mem_be);
      end
      checks++;
      if (bus.mem_addr !== 32'h40 || bus.mem_wdata !== 32'h12345678) begin
         errors++; $display("FAIL dwr_c1_bus got addr=%h wdata=%h want 00000040 12345678", bus.mem_addr, bus.mem_wdata);
      end
      bus.d_wdata = 32'hFFFFFFFF;
      bus.d_be    = 4'hF;
      tick();
      checks++;
      if (bus.mem_wen !== 1'b1 || bus.mem_be !== 4'b0011 || bus.mem_wdata !== 32'h12345678) begin
         errors++; $display("FAIL dwr_c2 got wen=%b be=%b wdata=%h want 1 0011 12345678", bus.mem_wen, bus.mem_be, bus.mem_wdata);
      end
      tick();
      checks++;
      if ({bus.i_ack, bus.d_ack, bus.mem_wen} !== 3'b010) begin
         errors++; $display("FAIL dwr_ack got i_ack/d_ack/wen=%b want 010", {bus.i_ack, bus.d_ack, bus.mem_wen});
      end
      checks++;
      if (bus.d_rdata !== 32'h0) begin
         errors++; $display("FAIL dwr_rdata got %h want 00000000", bus.d_rdata);
      end
      bus.d_req = 1'b0;
      bus.d_we  = 1'b0;
      tick();
      checks++;
      if (mem_q[8'h10] !== 32'hAAAA5678 || bus.d_ack !== 1'b0) begin
         errors++; $display("FAIL dwr_mem got word=%h ack=%b want aaaa5678 0", mem_q[8'h10], bus.d_ack);
      end
   endtask

   task automatic test_tie();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      bus.i_addr = 32'h200;
      bus.d_addr = 32'h80;
      bus.d_we   = 1'b0;
      bus.i_req  = 1'b1;
      bus.d_req  = 1'b1;
      tick();
      checks++;
      if (bus.mem_addr !== 32'h200 || bus.mem_ren !== 1'b1) begin
         errors++; $display("FAIL tie1_grant got addr=%h ren=%b want 00000200 1", bus.mem_addr, bus.mem_ren);
      end
      tick(); tick();
      checks++;
      if ({bus.i_ack, bus.d_ack} !== 2'b10 || bus.i_rdata !== 32'h11112222) begin
         errors++; $display("FAIL tie1_ack got acks=%b rd=%h want 10 11112222", {bus.i_ack, bus.d_ack}, bus.i_rdata);
      end
      bus.i_req = 1'b0;
      tick();
      checks++;
      if (bus.busy !== 1'b0 || {bus.i_ack, bus.d_ack} !== 2'b00) begin
         errors++; $display("FAIL tie1_idle got busy=%b acks=%b want 0 00", bus.busy, {bus.i_ack, bus.d_ack});
      end
      tick();
      checks++;
      if (bus.mem_addr !== 32'h80 || bus.mem_ren !== 1'b1) begin
         errors++; $display("FAIL tie2_grant got addr=%h ren=%b want 00000080 1", bus.mem_addr, bus.mem_ren);
      end
      tick(); tick();
      checks++;
      if ({bus.i_ack, bus.d_ack} !== 2'b01 || bus.d_rdata !== 32'h55667788) begin
         errors++; $display("FAIL tie2_ack got acks=%b rd=%h want 01 55667788", {bus.i_ack, bus.d_ack}, bus.d_rdata);
      end
      bus.i_req = 1'b1;
      tick();
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++; $display("FAIL tie3_idle got busy=%b want 0", bus.busy);
      end
      tick();
      checks++;
      if (bus.mem_addr !== 32'h200) begin
         errors++; $display("FAIL tie3_grant got addr=%h want 00000200", bus.mem_addr);
      end
      tick(); tick();
      checks++;
      if ({bus.i_ack, bus.d_ack} !== 2'b10) begin
         errors++; $display("FAIL tie3_ack got acks=%b want 10", {bus.i_ack, bus.d_ack});
      end
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      tick();
   endtask

   task automatic test_alternate();
      logic        exp_d;
      logic [31:0] exp_addr;
      bus.i_req = 1'b1;
      bus.d_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_d    = (k % 2 == 0);
         exp_addr = exp_d ? 32'h80 : 32'h200;
         tick();
         checks++;
         if (bus.mem_addr !== exp_addr) begin
            errors++; $display("FAIL alt_grant %0d got addr=%h want %h", k, bus.mem_addr, exp_addr);
         end
         tick(); tick();
         checks++;
         if ({bus.i_ack, bus.d_ack} !== {~exp_d, exp_d}) begin
            errors++; $display("FAIL alt_ack %0d got acks=%b want %b", k, {bus.i_ack, bus.d_ack}, {~exp_d, exp_d});
         end
         if (k == 3) begin
            bus.i_req = 1'b0;
            bus.d_req = 1'b0;
         end
         tick();
         checks++;
         if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL alt_idle %0d got busy=%b want 0", k, bus.busy);
         end
      end
   endtask

   task automatic test_reset_mid();
      bus.d_addr  = 32'h44;
      bus.d_wdata = 32'hCAFEF00D;
      bus.d_be    = 4'hF;
      bus.d_we    = 1'b1;
      bus.d_req   = 1'b1;
      tick();
      tick();
      checks++;
      if (bus.mem_wen !== 1'b1) begin
         errors++; $display("FAIL rmid_c2 got wen=%b want 1", bus.mem_wen);
      end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({bus.mem_wen, bus.mem_ren, bus.busy, bus.i_ack, bus.d_ack} !== 5'd0) begin
         errors++; $display("FAIL rmid_drop got wen/ren/busy/acks=%b want 00000",
                            {bus.mem_wen, bus.mem_ren, bus.busy, bus.i_ack, bus.d_ack});
      end
      checks++;
      if (bus.i_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin
         errors++; $display("FAIL rmid_rdata got i=%h d=%h want 0 0", bus.i_rdata, bus.d_rdata);
      end
      bus.d_req = 1'b0;
      bus.d_we  = 1'b0;
      tick(); tick();
      checks++;
      if (bus.d_ack !== 1'b0 || bus.busy !== 1'b0) begin
         errors++; $display("FAIL rmid_noack got ack=%b busy=%b want 0 0", bus.d_ack, bus.busy);
      end
      reset = 1'b1;
      tick();
      bus.i_addr = 32'h100;
      bus.i_req  = 1'b1;
      tick();
      checks++;
      if (bus.mem_addr !== 32'h100 || bus.mem_ren !== 1'b1) begin
         errors++; $display("FAIL rmid_ird got addr=%h ren=%b want 00000100 1", bus.mem_addr, bus.mem_ren);
      end
      tick(); tick();
      checks++;
      if ({bus.i_ack, bus.d_ack} !== 2'b10 || bus.i_rdata !== 32'hDEADBEEF) begin
         errors++; $display("FAIL rmid_iack got acks=%b rd=%h want 10 deadbeef", {bus.i_ack, bus.d_ack}, bus.i_rdata);
      end
      bus.i_req = 1'b0;
      tick();
   endtask

   initial begin
      reset       = 1'b0;
      pl_en       = 1'b0;
      pl_idx      = 8'h0;
      pl_data     = 32'h0;
      bus.i_req   = 1'b0;
      bus.i_addr  = 32'h0;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_addr  = 32'h0;
      bus.d_wdata = 32'h0;
      bus.d_be    = 4'h0;
      preload(8'h10, 32'hAAAAAAAA);
      preload(8'h40, 32'hDEADBEEF);
      preload(8'h20, 32'h55667788);
      preload(8'h80, 32'h11112222);
      preload(8'h11, 32'h00000000);
      test_reset();
      test_i_read();
      test_d_write();
      test_tie();
      test_alternate();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got no finish want finish");
      $fatal(1, "timeout");
   end

endmodule
